// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing a single FIFO write port between NUM_REQ producers.
// An owner keeps the port for up to MAX_BURST writes, then ownership rotates.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       fifo_full,
    output logic                       fifo_write_en,
    output logic [DATA_W-1:0]          fifo_write_data,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       dbg_state,
    output logic [3:0]                 dbg_burst_cnt
);

    localparam int OW = $clog2(NUM_REQ);

    // Handshake: req[i] is a valid held high with stable data until a cycle
    // where gnt[i]=1; that cycle is the transfer and the producer then advances.
    // fifo_full acts as the downstream not-ready and blocks gnt/fifo_write_en.

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [OW-1:0] owner_q, owner_nxt;
    logic [OW-1:0] last_owner, last_owner_nxt;
    logic [3:0]    burst_cnt, burst_cnt_nxt;

    logic          pick_found;
    logic [OW-1:0] pick_idx;

    // Search starts just after the previous owner so that owner gets lowest priority.
    always_comb begin
        logic [OW-1:0] cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = last_owner + OW'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner_q    <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            burst_cnt  <= 4'd0;
        end else begin
            state      <= state_nxt;
            owner_q    <= owner_nxt;
            last_owner <= last_owner_nxt;
            burst_cnt  <= burst_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner_q;
        last_owner_nxt  = last_owner;
        burst_cnt_nxt   = burst_cnt;
        gnt             = '0;
        fifo_write_en   = 1'b0;
        fifo_write_data = '0;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_nxt     = pick_idx;
                    burst_cnt_nxt = 4'd0;
                    state_nxt     = OWN;
                end
            end
            OWN: begin
                if (!req[owner_q]) begin
                    // A dropped request wins over a full FIFO.
                    state_nxt      = IDLE;
                    last_owner_nxt = owner_q;
                end else if (!fifo_full) begin
                    gnt[owner_q]    = 1'b1;
                    fifo_write_en   = 1'b1;
                    fifo_write_data = req_data[int'(owner_q)*DATA_W +: DATA_W];
                    burst_cnt_nxt   = burst_cnt + 4'd1;
                    if (burst_cnt + 4'd1 == 4'(MAX_BURST)) begin
                        state_nxt      = IDLE;
                        last_owner_nxt = owner_q;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy          = (state == OWN);
    assign owner         = owner_q;
    assign dbg_state     = (state == OWN);
    assign dbg_burst_cnt = burst_cnt;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector bench for fifo_wr_arbiter: per-cycle expected outputs plus
// a write-data scoreboard fed from the granted requester's slice.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_write_en;
    logic [7:0]  fifo_write_data;
    logic        busy;
    logic [1:0]  owner;
    logic        dbg_state;
    logic [3:0]  dbg_burst_cnt;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(4)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_data(req_data),
        .gnt(gnt),
        .fifo_full(fifo_full),
        .fifo_write_en(fifo_write_en),
        .fifo_write_data(fifo_write_data),
        .busy(busy),
        .owner(owner),
        .dbg_state(dbg_state),
        .dbg_burst_cnt(dbg_burst_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rs;
        logic [3:0]  req;
        logic [31:0] data;
        logic        full;
        logic [3:0]  gnt;
        logic        we;
        logic [7:0]  wd;
        logic        busy;
        logic [1:0]  own;
        logic [3:0]  cnt;
    } vec_t;

    localparam logic [31:0] D = 32'h44332211;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // vector builders
    task automatic add_v(input bit rs, input logic [3:0] rq, input logic [31:0] d, input logic f,
                         input logic [3:0] g, input logic we, input logic [7:0] wd,
                         input logic b, input logic [1:0] o, input logic [3:0] c);
        vec_t v;
        v.rs = rs; v.req = rq; v.data = d; v.full = f; v.gnt = g; v.we = we;
        v.wd = wd; v.busy = b; v.own = o; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic add_idle(input bit rs, input logic [3:0] rq, input logic [31:0] d,
                            input logic [1:0] o, input logic [3:0] c);
        add_v(rs, rq, d, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, o, c);
    endtask

    task automatic add_wr(input logic [3:0] rq, input logic [31:0] d, input logic [3:0] g,
                          input logic [7:0] wd, input logic [1:0] o, input logic [3:0] c);
        add_v(1'b0, rq, d, 1'b0, g, 1'b1, wd, 1'b1, o, c);
    endtask

    task automatic add_hold(input logic [3:0] rq, input logic [31:0] d, input logic f,
                            input logic [1:0] o, input logic [3:0] c);
        add_v(1'b0, rq, d, f, 4'b0000, 1'b0, 8'h00, 1'b1, o, c);
    endtask

    // driver tasks
    task automatic do_reset();
        @(negedge clk);
        req = 4'b0; req_data = 32'h0; fifo_full = 1'b0; reset = 1'b0;
        #1;
        check("rst gnt",   gnt, 4'b0);
        check("rst we",    fifo_write_en, 1'b0);
        check("rst wd",    fifo_write_data, 8'h00);
        check("rst busy",  busy, 1'b0);
        check("rst owner", owner, 2'd0);
        check("rst cnt",   dbg_burst_cnt, 4'd0);
        exp_q.delete();
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        req = v.req; req_data = v.data; fifo_full = v.full;
        #1;
        check($sformatf("v%0d gnt", idx),   gnt, v.gnt);
        check($sformatf("v%0d we", idx),    fifo_write_en, v.we);
        check($sformatf("v%0d wd", idx),    fifo_write_data, v.wd);
        check($sformatf("v%0d busy", idx),  busy, v.busy);
        check($sformatf("v%0d owner", idx), owner, v.own);
        check($sformatf("v%0d cnt", idx),   dbg_burst_cnt, v.cnt);
        check($sformatf("v%0d onehot", idx), ($countones(gnt) <= 1), 1'b1);
        check($sformatf("v%0d gnt_no_req", idx), |(gnt & ~req), 1'b0);
        // scoreboard: the granted requester's slice is what must reach the FIFO
        for (int i = 0; i < 4; i++)
            if (gnt[i] === 1'b1) exp_q.push_back(req_data[i*8 +: 8]);
        if (fifo_write_en === 1'b1) begin
            if (exp_q.size() == 0) check($sformatf("v%0d sb_empty", idx), 1'b1, 1'b0);
            else check($sformatf("v%0d sb_data", idx), fifo_write_data, exp_q.pop_front());
        end
    endtask

    initial begin
        reset = 1'b0; req = 4'b0; req_data = 32'h0; fifo_full = 1'b0;

        // Single requester, three writes with advancing data, then drop
        add_idle(1'b1, 4'b0001, 32'h00000011, 2'd0, 4'd0);
        add_wr(4'b0001, 32'h00000011, 4'b0001, 8'h11, 2'd0, 4'd0);
        add_wr(4'b0001, 32'h00000022, 4'b0001, 8'h22, 2'd0, 4'd1);
        add_wr(4'b0001, 32'h00000033, 4'b0001, 8'h33, 2'd0, 4'd2);
        add_hold(4'b0000, 32'h0, 1'b0, 2'd0, 4'd3);
        add_idle(1'b0, 4'b0000, 32'h0, 2'd0, 4'd3);

        // All four continuous: 0,1,2,3,0 with one idle cycle between owners
        add_idle(1'b1, 4'b1111, D, 2'd0, 4'd0);
        for (int o = 0; o < 4; o++) begin
            for (int c = 0; c < 4; c++)
                add_wr(4'b1111, D, 4'(1 << o), 8'((o + 1) * 8'h11), 2'(o), 4'(c));
            add_idle(1'b0, 4'b1111, D, 2'(o), 4'd4);
        end
        add_wr(4'b1111, D, 4'b0001, 8'h11, 2'd0, 4'd0);

        // FIFO full for 3 cycles after the 2nd write of owner 1
        add_idle(1'b1, 4'b1111, D, 2'd0, 4'd0);
        for (int c = 0; c < 4; c++) add_wr(4'b1111, D, 4'b0001, 8'h11, 2'd0, 4'(c));
        add_idle(1'b0, 4'b1111, D, 2'd0, 4'd4);
        add_wr(4'b1111, D, 4'b0010, 8'h22, 2'd1, 4'd0);
        add_wr(4'b1111, D, 4'b0010, 8'h22, 2'd1, 4'd1);
        for (int s = 0; s < 3; s++) add_hold(4'b1111, D, 1'b1, 2'd1, 4'd2);
        add_wr(4'b1111, D, 4'b0010, 8'h22, 2'd1, 4'd2);
        add_wr(4'b1111, D, 4'b0010, 8'h22, 2'd1, 4'd3);
        add_idle(1'b0, 4'b1111, D, 2'd1, 4'd4);

        // Owner 2 drops after 2 writes (with full high that cycle); next owner is 3
        add_idle(1'b1, 4'b0100, D, 2'd0, 4'd0);
        add_wr(4'b1101, D, 4'b0100, 8'h33, 2'd2, 4'd0);
        add_wr(4'b1101, D, 4'b0100, 8'h33, 2'd2, 4'd1);
        add_hold(4'b1001, D, 1'b1, 2'd2, 4'd2);
        add_idle(1'b0, 4'b1001, D, 2'd2, 4'd2);
        add_wr(4'b1001, D, 4'b1000, 8'h44, 2'd3, 4'd0);

        // Sparse: only 0 and 2 request; grants 0,2,0,2
        add_idle(1'b1, 4'b0101, D, 2'd0, 4'd0);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++)
                add_wr(4'b0101, D, (r % 2 == 0) ? 4'b0001 : 4'b0100,
                       (r % 2 == 0) ? 8'h11 : 8'h33, (r % 2 == 0) ? 2'd0 : 2'd2, 4'(c));
            add_idle(1'b0, 4'b0101, D, (r % 2 == 0) ? 2'd0 : 2'd2, 4'd4);
        end
        add_wr(4'b0101, D, 4'b0100, 8'h33, 2'd2, 4'd0);

        foreach (vecs[i]) begin
            if (vecs[i].rs) do_reset();
            apply_vec(vecs[i], i);
        end

        // Async reset mid-burst: owner 1 with burst_cnt 2
        vecs.delete();
        add_idle(1'b1, 4'b1111, D, 2'd0, 4'd0);
        for (int c = 0; c < 4; c++) add_wr(4'b1111, D, 4'b0001, 8'h11, 2'd0, 4'(c));
        add_idle(1'b0, 4'b1111, D, 2'd0, 4'd4);
        add_wr(4'b1111, D, 4'b0010, 8'h22, 2'd1, 4'd0);
        add_wr(4'b1111, D, 4'b0010, 8'h22, 2'd1, 4'd1);
        foreach (vecs[i]) begin
            if (vecs[i].rs) do_reset();
            apply_vec(vecs[i], 1000 + i);
        end
        @(negedge clk);
        req = 4'b1111; req_data = D; fifo_full = 1'b0;
        #1;
        check("mid owner", owner, 2'd1);
        check("mid cnt",   dbg_burst_cnt, 4'd2);
        check("mid we",    fifo_write_en, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async we",    fifo_write_en, 1'b0);
        check("async gnt",   gnt, 4'b0);
        check("async busy",  busy, 1'b0);
        check("async wd",    fifo_write_data, 8'h00);
        check("async owner", owner, 2'd0);
        check("async cnt",   dbg_burst_cnt, 4'd0);
        exp_q.delete();
        @(posedge clk);
        #2 reset = 1'b1;
        vecs.delete();
        add_idle(1'b0, 4'b1111, D, 2'd0, 4'd0);
        add_wr(4'b1111, D, 4'b0001, 8'h11, 2'd0, 4'd0);
        foreach (vecs[i]) apply_vec(vecs[i], 2000 + i);

        check("sb drained", exp_q.size(), 0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one sync_fifo write port (write_en / write_data / full) between NUM_REQ producers.
- Grants ownership to one requester at a time for a bounded burst, then rotates.
- Sits directly in front of the FIFO write side; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4: number of requesters; must be a power of two, 2..8.
- DATA_W, 8: data width; matches the FIFO word width.
- MAX_BURST, 4: maximum writes per ownership; range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester write request; held high while the requester has data.
- req_data  in  NUM_REQ*DATA_W  per-requester data; slice i is bits [i*DATA_W +: DATA_W].
- gnt  out  NUM_REQ  one-hot; gnt[i]=1 means req_data slice i is written this cycle and the requester advances its data.
- fifo_full  in  1  the FIFO full flag.
- fifo_write_en  out  1  to the FIFO write_en.
- fifo_write_data  out  DATA_W  to the FIFO write_data.
- busy  out  1  1 while in OWN state.
- owner  out  clog2(NUM_REQ)  current or last owner index.

Behaviour:
- State machine has two states: IDLE and OWN. Registers: state, owner, last_owner, burst_cnt (4 bits).
- Reset (asserted low, async) sets:
  - state=IDLE, owner=0, last_owner=NUM_REQ-1, burst_cnt=0.
  - As a consequence gnt=0, fifo_write_en=0, fifo_write_data=0, busy=0.
  - With last_owner=NUM_REQ-1, requester 0 has first priority after reset.
  - Reset mid-burst aborts the burst immediately; no partial state survives.
- IDLE:
  - If any req bit is set, choose the first set index searching last_owner+1, last_owner+2, ... modulo NUM_REQ (wrap-around).
  - Load owner with that index, clear burst_cnt, and enter OWN next cycle.
  - No write occurs in IDLE, so arbitration costs 1 cycle.
  - If no req bit is set, stay in IDLE.
- OWN, write condition is req[owner]=1 and fifo_full=0. Outputs are combinational in the same cycle:
  - fifo_write_en=1.
  - gnt = one-hot(owner).
  - fifo_write_data = req_data slice owner.
  - burst_cnt increments.
- OWN, fifo_full=1:
  - fifo_write_en=0 and gnt=0.
  - burst_cnt holds; stay in OWN. A stall never causes a release.
- OWN, release conditions (next state IDLE, last_owner<=owner):
  - req[owner]=0 in any OWN cycle: release with no write that cycle.
  - The write that brings burst_cnt to MAX_BURST: release after that write.
  - If req[owner]=0 and fifo_full=1 in the same cycle, the req drop takes priority and the block releases.
- Output rules:
  - fifo_write_data=0 whenever fifo_write_en=0.
  - gnt is never asserted for a requester whose req is low.
  - At most one gnt bit is ever set.
- Requests from non-owners are ignored until the next IDLE. Requesters must hold req and data stable until granted.
- Throughput: MAX_BURST writes per MAX_BURST+1 cycles under continuous requests with a non-full FIFO.

Test Plan:
- Single requester: req[0]=1 for 3 grants, then low, data 0x11, 0x22, 0x33.
  - Required: 1 IDLE cycle, then write_en on 3 consecutive cycles with those values and gnt=4'b0001.
  - Then release; busy drops the cycle after req falls.
- All four requesters continuous, MAX_BURST=4.
  - Required: owner sequence 0,1,2,3,0; exactly 4 writes per owner; exactly one idle cycle between owners.
- fifo_full high for 3 cycles after the 2nd write of owner 1.
  - Required: write_en=0 and gnt=0 for those 3 cycles; owner stays 1 and burst_cnt stays 2.
  - Then the 3rd and 4th writes occur, then release.
- Owner 2 drops req after its 2nd write while req[3] and req[0] are high.
  - Required: release with 2 writes; next owner is 3, not 0.
- Sparse requests: only req[0] and req[2] active after reset.
  - Required: grants go 0, 2, 0, 2; requesters 1 and 3 are skipped with no extra idle cycles.
- Assert reset low mid-burst (owner 1, burst_cnt=2) asynchronously, between clock edges.
  - Required: write_en, gnt and busy go to 0 immediately.
  - After release of reset with all req high, the first owner is 0.
